// File: rtl/ena_pattern_gen.sv
// Serialises a latched bit pattern MSB-first onto ena, then drains, while counting triggers.
// Optional PAT_GEN_LOOP_EN adds a loop input that replays the pattern back-to-back.
module ena_pattern_gen #(
  parameter int unsigned PAT_W     = 16,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             trigger,
`ifdef PAT_GEN_LOOP_EN
  input  logic             loop,
`endif
  output logic             ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] trig_count
);

  localparam int unsigned DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDrain} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] bits_q, bits_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             ena_q, ena_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             len_ok;
  logic             loop_en;
  logic [PAT_W-1:0] first_sh, next_sh;

`ifdef PAT_GEN_LOOP_EN
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] reload_sh;
  assign loop_en   = loop;
  assign reload_sh = pat_q >> (len_q - 1'b1);
`else
  assign loop_en = 1'b0;
`endif

  assign len_ok   = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));
  // Shifting instead of indexing keeps the bit select width-agnostic.
  assign first_sh = pattern >> (pat_len - 1'b1);
  assign next_sh  = pat_q >> (bits_q - 1'b1);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    bits_d  = bits_q;
    drain_d = drain_q;
    ena_d   = ena_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef PAT_GEN_LOOP_EN
    len_d   = len_q;
`endif

    if (busy_q && trigger && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start && len_ok) begin
          pat_d   = pattern;
          ena_d   = first_sh[0];
          busy_d  = 1'b1;
          cnt_d   = '0;
          bits_d  = pat_len - 1'b1;
          state_d = StShift;
`ifdef PAT_GEN_LOOP_EN
          len_d   = pat_len;
`endif
        end
      end
      StShift: begin
        if (bits_q != '0) begin
          ena_d  = next_sh[0];
          bits_d = bits_q - 1'b1;
        end else if (loop_en) begin
`ifdef PAT_GEN_LOOP_EN
          ena_d  = reload_sh[0];
          bits_d = len_q - 1'b1;
`endif
        end else begin
          ena_d = 1'b0;
          if (DRAIN_CYC == 0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            drain_d = DW'(DRAIN_CYC);
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        ena_d   = 1'b0;
        drain_d = drain_q - 1'b1;
        if (drain_q <= DW'(1)) begin
          drain_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pat_q   <= '0;
      bits_q  <= '0;
      drain_q <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef PAT_GEN_LOOP_EN
      len_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      bits_q  <= bits_d;
      drain_q <= drain_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef PAT_GEN_LOOP_EN
      len_q   <= len_d;
`endif
    end
  end

  assign ena        = ena_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_count = cnt_q;

endmodule

// File: tb/tb_ena_pattern_gen.sv
// Scoreboard bench: driver pushes expected runs, negedge monitor pops and checks on done.
module tb_ena_pattern_gen;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  pat_len = '0;
`ifdef PAT_GEN_LOOP_EN
  logic        loop = 1'b0;
`endif
  logic        ena, busy, done;
  logic [7:0]  trig_count;
  logic        ena_s, busy_s, done_s;
  logic [1:0]  trig_count_s;

  always #5 clk = ~clk;

  ena_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .pat_len(pat_len),
    .trigger(trigger),
`ifdef PAT_GEN_LOOP_EN
    .loop(loop),
`endif
    .ena(ena), .busy(busy), .done(done), .trig_count(trig_count)
  );

  ena_pattern_gen #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .pat_len(pat_len),
    .trigger(trigger),
`ifdef PAT_GEN_LOOP_EN
    .loop(loop),
`endif
    .ena(ena_s), .busy(busy_s), .done(done_s), .trig_count(trig_count_s)
  );

  typedef struct {
    int          n;
    logic [63:0] seq;
    int          cnt;
    int          cnt_s;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   last_cnt = 0;
  int   last_cnt_s = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    logic [63:0] obs;
    int          obs_n;
    logic        prev_done;
    exp_t        e;
    obs = '0; obs_n = 0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        obs = '0; obs_n = 0; prev_done = 1'b0;
      end else begin
        if (busy) begin
          obs = {obs[62:0], ena};
          obs_n++;
        end else begin
          check("idle_ena", ena, 0);
        end
        if (done) begin
          check("done_width", prev_done, 0);
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("busy_cycles", obs_n, e.n);
            check("ena_seq", obs, e.seq);
            check("trig_count", trig_count, e.cnt);
            check("trig_count_sat", trig_count_s, e.cnt_s);
          end
          obs = '0; obs_n = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 300) begin
      trigger = 1'($urandom);
      @(posedge clk); #1;
      w++;
    end
    if (w >= 300) check("idle_timeout", 1, 0);
  endtask

  task automatic run(input logic [15:0] pat, input int len, input int passes,
                     input logic [63:0] tmask, input bit glitch, input bit check_clear);
    exp_t e;
    int   c;
    bit   valid;
    wait_idle();
    valid = (len >= 1) && (len <= 16);
    if (valid) begin
      e.n = len * passes + DRAIN;
      e.seq = '0;
      for (int p = 0; p < passes; p++)
        for (int i = len - 1; i >= 0; i--) e.seq = {e.seq[62:0], pat[i]};
      for (int d = 0; d < DRAIN; d++) e.seq = {e.seq[62:0], 1'b0};
      c = 0;
      for (int k = 0; k < e.n; k++) c += int'(tmask[k]);
      e.cnt   = (c > 255) ? 255 : c;
      e.cnt_s = (c > 3) ? 3 : c;
      sb.push_back(e);
    end
    pattern = pat;
    pat_len = 5'(len);
    start   = 1'b1;
    trigger = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    if (!valid) begin
      for (int k = 0; k < 3; k++) begin
        check("rejected_busy", busy, 0);
        check("rejected_done", done, 0);
        check("hold_count", trig_count, last_cnt);
        check("hold_count_sat", trig_count_s, last_cnt_s);
        trigger = 1'($urandom);
        @(posedge clk); #1;
      end
      return;
    end
    if (check_clear) check("count_cleared", trig_count, 0);
    for (int k = 0; k < e.n; k++) begin
      trigger = tmask[k];
`ifdef PAT_GEN_LOOP_EN
      loop = (k < len * (passes - 1));
`endif
      pattern = 16'($urandom);
      pat_len = 5'($urandom);
      start   = glitch && (k == 1);
      @(posedge clk); #1;
    end
    start   = 1'b0;
    trigger = 1'b0;
    @(negedge clk); #1;
    check("done_seen", sb.size(), 0);
    last_cnt   = e.cnt;
    last_cnt_s = e.cnt_s;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ena", ena, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", trig_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: 0x02DD/11 with triggers in cycles 2, 5 and 12 (drain)
    run(16'h02DD, 11, 1, 64'h1024, 1'b0, 1'b0);
    run(16'hABCD, 0, 1, '0, 1'b0, 1'b0);
    run(16'hABCD, 17, 1, '0, 1'b0, 1'b0);
    run(16'h0001, 1, 1, 64'h0, 1'b1, 1'b1);
    run(16'h5A5A, 16, 1, '1, 1'b1, 1'b1);

    // Asynchronous reset mid-shift: outputs clear at once and no done follows
    wait_idle();
    pattern = 16'hFFFF; pat_len = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; trigger = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ena", ena, 0);
    check("arst_busy", busy, 0);
    check("arst_count", trig_count, 0);
    check("arst_count_sat", trig_count_s, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      trigger = 1'($urandom);
      check("post_rst_busy", busy, 0);
      @(posedge clk); #1;
    end
    last_cnt = 0; last_cnt_s = 0;

`ifdef PAT_GEN_LOOP_EN
    run(16'h000B, 4, 3, 64'h2_1001, 1'b0, 1'b1);
`endif

    for (int r = 0; r < 40; r++) begin
      int passes;
      passes = 1;
`ifdef PAT_GEN_LOOP_EN
      passes = $urandom_range(1, 3);
`endif
      run(16'($urandom), $urandom_range(0, 18), passes, {$urandom, $urandom},
          1'($urandom), 1'b1);
    end

    wait_idle();
    repeat (4) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ena_pattern_gen.md
Name: ena_pattern_gen

Overview:
- Stimulus-side counterpart of the ena-driven trigger detector. It serialises a programmed bit pattern onto an `ena` line, one bit per clock.
- It also counts the `trigger` pulses returned by the detector during the run.
- Used as a self-checking source in front of the detector, or as a sequencer driving any block that takes a 1-bit enable stream.

Parameters:
- PAT_W, 16: maximum pattern length in bits; pattern register width.
- LEN_W, 5: width of `pat_len`; must hold PAT_W.
- CNT_W, 8: width of the trigger counter.
- DRAIN_CYC, 2: idle cycles (ena=0) after the last bit, used to catch late triggers.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled on rising clk when IDLE.
- pattern  input  PAT_W  bits to send; bit [pat_len-1] is sent first, bit [0] last.
- pat_len  input  LEN_W  number of bits to send; valid range 1..PAT_W.
- trigger  input  1  response from the detector; sampled every clk while busy.
- ena  output  1  serial pattern bit (registered).
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse at the end of a run.
- trig_count  output  CNT_W  cycles with trigger=1 during the last/current run.

Behaviour:
- Clock and reset are decided: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: state=IDLE; ena=0, busy=0, done=0, trig_count=0; internal shift register, bit counter and drain counter = 0. Reset assertion mid-run forces these values immediately, not waiting for clk. No done pulse is generated for an aborted run.
- FSM states: IDLE, SHIFT, DRAIN.
- IDLE, start=1, pat_len in 1..PAT_W:
  - Latch pattern and pat_len.
  - On the same edge: ena<=pattern[pat_len-1], busy<=1, trig_count<=0, bits_left<=pat_len-1; go to SHIFT.
  - Result: the first bit appears on ena in the cycle after the accepting edge (latency 1).
- IDLE, start=1, pat_len=0 or pat_len>PAT_W: request ignored; stay IDLE, no busy, no done.
- SHIFT:
  - Each edge with bits_left>0: ena<=next lower bit; bits_left decrements.
  - Edge with bits_left=0: ena<=0, drain counter<=DRAIN_CYC; go to DRAIN.
  - If DRAIN_CYC=0, go directly to the done edge instead.
  - ena holds each bit for exactly one clk period, so a run occupies exactly pat_len cycles of pattern output.
- DRAIN:
  - ena=0; drain counter decrements each edge.
  - On the edge where it reaches 0: busy<=0, done<=1 for one cycle; go to IDLE.
- trig_count:
  - Increments on each edge where busy=1 and trigger=1, including DRAIN cycles.
  - Saturates at 2^CNT_W-1; no wrap.
  - Holds its value after done until the next accepted start.
- start while busy is ignored and does not restart or extend the run. start on the same edge as done is ignored, because the state is not yet IDLE; a new run needs start in a later IDLE cycle.
- pattern and pat_len may change freely after acceptance; only the latched copies are used.
- trigger is sampled directly. It is synchronous to clk by contract, with no synchroniser.

Optional Feature:
- Macro: PAT_GEN_LOOP_EN.
- Defined: adds input port `loop` (1 bit).
  - In SHIFT, on the edge with bits_left=0 and loop=1: reload ena<=latched pattern[len-1] and bits_left<=len-1; no DRAIN, no gap cycle, busy stays 1.
  - trig_count keeps accumulating, still saturating.
  - Deasserting loop lets the current pass finish, then normal DRAIN and done.
- Not defined: no `loop` port; single pass only, exactly as above.

Test Plan:
- Reset check: rst_n=0 for 2 clk -> ena=0, busy=0, done=0, trig_count=0.
  - Then assert rst_n=0 asynchronously mid-SHIFT of a run -> all outputs 0 immediately; after release, no done pulse.
- Basic run: pattern=16'h02DD, pat_len=11, start for 1 clk -> ena = 0,1,0,1,1,0,1,1,1,0,1 over 11 cycles starting 1 cycle after the accepting edge.
  - busy high for 11+2 cycles; done pulses on the 13th edge after acceptance; ena=0 during drain.
- Trigger counting: same run with the bench asserting trigger on 3 separate cycles, one of them in DRAIN -> trig_count=3 at done.
  - trig_count holds 3 afterwards and clears on the next start.
- Boundaries:
  - pat_len=1, pattern[0]=1 -> ena high for exactly 1 cycle, done 3 cycles later.
  - pat_len=0 and pat_len=17 -> no busy, no done.
  - start pulsed while busy -> run unchanged.
- Saturation: CNT_W=2, pat_len=16, trigger held at 1 -> trig_count stops at 3.
- Loop (PAT_GEN_LOOP_EN): pattern=4'b1011, len=4, loop=1 for 2 passes then 0 -> ena = 1011 1011 1011 with no gap.
  - Then 2 drain cycles, one done pulse, trig_count accumulated across all passes.
